// File: rtl/flappy_pkg.sv
// flappy_pkg: shared game-state type and BCD constants for the score path
package flappy_pkg;
  typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;
  localparam logic [3:0] BCD_BLANK     = 4'hF;
  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
endpackage

// File: rtl/bcd_digit_inc.sv
// bcd_digit_inc: one BCD digit of a ripple incrementer, 9 plus carry wraps to 0
module bcd_digit_inc
  import flappy_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       cin,
  output logic [3:0] next_digit,
  output logic       cout
);
  assign cout       = cin && (digit == BCD_MAX_DIGIT);
  assign next_digit = cout ? 4'd0 : digit + {3'd0, cin};
endmodule

// File: rtl/score_bcd_counter.sv
// score_bcd_counter: BCD game score and volatile high score feeding the seg7 digits
module score_bcd_counter
  import flappy_pkg::*;
#(
  parameter int NUM_DIGITS    = 3,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    pass,
  input  logic                    crash,
  input  logic                    show_high,
  output logic [4*NUM_DIGITS-1:0] score,
  output logic [4*NUM_DIGITS-1:0] high,
  output logic [4*NUM_DIGITS-1:0] disp,
  output logic                    playing
);
  state_t                  r_state;
  logic [4*NUM_DIGITS-1:0] r_score;
  logic [4*NUM_DIGITS-1:0] r_high;
  logic                    r_pass_q;
  logic                    r_playing;
  logic                    w_edge;
  logic                    w_inc;
  logic                    w_nz;
  logic [NUM_DIGITS:0]     w_carry;
  logic [4*NUM_DIGITS-1:0] w_next;
  logic [4*NUM_DIGITS-1:0] w_sel;
  // The chain is fed the raw pass edge so its final carry flags an all-nines score,
  // which then suppresses the update instead of letting the score wrap.
  assign w_edge     = pass && !r_pass_q;
  assign w_carry[0] = w_edge;
  assign w_inc      = w_edge && !w_carry[NUM_DIGITS];
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
    bcd_digit_inc u_inc (
      .digit     (r_score[4*i +: 4]),
      .cin       (w_carry[i]),
      .next_digit(w_next[4*i +: 4]),
      .cout      (w_carry[i+1])
    );
  end
  // Game FSM with pass edge register, score update and high-score capture on game over
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_score   <= '0;
      r_high    <= '0;
      r_pass_q  <= 1'b0;
      r_playing <= 1'b0;
    end else begin
      r_pass_q <= pass;
      case (r_state)
        IDLE, OVER: if (start) begin
          r_state   <= PLAY;
          r_score   <= '0;
          r_playing <= 1'b1;
        end
        PLAY: if (crash) begin
          r_state   <= OVER;
          r_playing <= 1'b0;
          if (r_score > r_high) r_high <= r_score;
        end else if (w_inc) r_score <= w_next;
        default: begin
          r_state   <= IDLE;
          r_playing <= 1'b0;
        end
      endcase
    end
  end
  assign w_sel = show_high ? r_high : r_score;
  // Blank each zero digit above digit 0 until the first nonzero one from the top
  always_comb begin
    w_nz = 1'b0;
    disp = w_sel;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      w_nz              = w_nz || (w_sel[4*i +: 4] != 4'd0);
      disp[4*i +: 4]    = (BLANK_LEADING && !w_nz) ? BCD_BLANK : w_sel[4*i +: 4];
    end
  end
  assign score   = r_score;
  assign high    = r_high;
  assign playing = r_playing;
endmodule

// File: tb/tb_score_bcd_counter.sv
// tb_score_bcd_counter: directed scoreboard bench for the BCD score keeper
module tb_score_bcd_counter;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        pass = 1'b0;
  logic        crash = 1'b0;
  logic        show_high = 1'b0;
  logic [11:0] score;
  logic [11:0] high;
  logic [11:0] disp;
  logic        playing;
  int checks = 0;
  int errors = 0;
  int m_score = 0;
  int m_high = 0;
  bit m_play = 1'b0;

  typedef struct {
    string       tag;
    int          which;
    logic [11:0] val;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  score_bcd_counter #(.NUM_DIGITS(3), .BLANK_LEADING(1'b1)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .pass     (pass),
    .crash    (crash),
    .show_high(show_high),
    .score    (score),
    .high     (high),
    .disp     (disp),
    .playing  (playing)
  );

  function automatic logic [11:0] bcd(int v);
    return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic logic [11:0] blanked(int v);
    logic [11:0] r;
    r = bcd(v);
    if (v < 100) r[11:8] = 4'hF;
    if (v < 10) r[7:4] = 4'hF;
    return r;
  endfunction

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(string tag, int which, logic [11:0] val);
    sb.push_back('{tag, which, val});
  endtask

  task automatic drain();
    while (sb.size() > 0) begin
      exp_t        e;
      logic [11:0] got;
      e   = sb.pop_front();
      got = e.which == 0 ? score : e.which == 1 ? high : e.which == 2 ? disp : {11'd0, playing};
      checks++;
      assert (got === e.val) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, got, e.val);
      end
    end
  endtask

  task automatic expect_all(string tag);
    push({tag, ".score"}, 0, bcd(m_score));
    push({tag, ".high"}, 1, bcd(m_high));
    push({tag, ".disp"}, 2, blanked(show_high ? m_high : m_score));
    push({tag, ".playing"}, 3, {11'd0, m_play});
    drain();
  endtask

  task automatic pulses(int n, int hi);
    repeat (n) begin
      pass = 1'b1;
      if (m_play && m_score < 999) m_score++;
      cyc(hi);
      pass = 1'b0;
      cyc(1);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    m_play = 1'b1;
    m_score = 0;
  endtask

  task automatic do_crash();
    crash = 1'b1;
    cyc(1);
    crash = 1'b0;
    m_play = 1'b0;
    if (m_score > m_high) m_high = m_score;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    cyc(1);
    reset_n = 1'b1;
    m_score = 0;
    m_high = 0;
    m_play = 1'b0;
    cyc(1);
  endtask

  initial begin
    cyc(2);
    expect_all("reset");
    reset_n = 1'b1;
    cyc(1);
    do_start();
    expect_all("start");
    pulses(12, 3);
    expect_all("twelve");
    pass = 1'b1;
    m_score++;
    cyc(10);
    pass = 1'b0;
    cyc(1);
    expect_all("held_once");
    pulses(29, 3);
    expect_all("s042");
    #2 reset_n = 1'b0;
    #1;
    m_score = 0;
    m_high = 0;
    m_play = 1'b0;
    expect_all("async_reset");
    cyc(1);
    reset_n = 1'b1;
    cyc(1);
    do_start();
    pulses(7, 3);
    do_crash();
    expect_all("game1_over");
    cyc(2);
    expect_all("over_holds");
    do_start();
    expect_all("game2_start");
    pulses(3, 3);
    do_crash();
    expect_all("game2_over");
    show_high = 1'b1;
    #1;
    expect_all("show_high");
    show_high = 1'b0;
    cyc(1);
    do_reset();
    do_start();
    pulses(5, 3);
    pass = 1'b1;
    do_crash();
    pass = 1'b0;
    expect_all("crash_with_pass");
    cyc(1);
    pulses(1, 3);
    expect_all("pass_in_over");
    pass = 1'b1;
    cyc(1);
    do_start();
    cyc(3);
    expect_all("pass_across_start");
    pass = 1'b0;
    cyc(1);
    pulses(1, 3);
    expect_all("rearmed");
    start = 1'b1;
    do_crash();
    start = 1'b0;
    expect_all("start_with_crash");
    cyc(1);
    do_start();
    pulses(99, 1);
    expect_all("s099");
    pulses(1, 1);
    expect_all("s100");
    pulses(899, 1);
    expect_all("s999");
    pulses(1, 1);
    expect_all("saturate");
    do_crash();
    expect_all("high999");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/score_bcd_counter.md
Name: score_bcd_counter

Overview:
- Game score keeper directly upstream of the 7-segment decoders.
- Counts pipes cleared by the bird in packed BCD and holds a high score across games.
- Drives one 4-bit BCD code per display digit. Each code feeds one seg7 instance.
- Leading zeros are blanked by emitting the non-BCD code 4'hF, which the decoder renders as all segments off.

Parameters:
- NUM_DIGITS, 3, number of BCD digits. Score range is 0 to 10^NUM_DIGITS-1.
- BLANK_LEADING, 1, when 1 leading zero digits of disp are replaced with 4'hF. When 0, zeros are shown.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  level; begins a new game from IDLE or OVER.
- pass  input  1  level; high while the bird is inside a pipe gap. A rising edge scores one point.
- crash  input  1  level; collision detected, ends the game.
- show_high  input  1  when 1, disp shows the high score; when 0, disp shows the current score.
- score  output  4*NUM_DIGITS  current score, packed BCD, digit 0 = LSD in bits [3:0].
- high  output  4*NUM_DIGITS  high score, packed BCD.
- disp  output  4*NUM_DIGITS  per-digit codes to the seg7 instances, with blanking applied.
- playing  output  1  1 while in state PLAY.

Behaviour:
- Reset (async assert, sync release): state=IDLE, score=0, high=0, pass_q=0, playing=0.
  - disp after reset = {4'hF,...,4'hF,4'h0} with BLANK_LEADING=1, otherwise all 4'h0.
- FSM states: IDLE, PLAY, OVER.
  - IDLE --start--> PLAY.
  - PLAY --crash--> OVER.
  - OVER --start--> PLAY.
  - All other inputs hold the current state.
- Entering PLAY: score is cleared to 0 on the same edge. The previous score stays visible in IDLE/OVER until start.
- Edge detect: pass_q <= pass every cycle, in every state.
  - inc = (state==PLAY) & pass & ~pass_q & ~crash.
  - pass held high across start therefore gives no point.
- Increment: on an edge with inc=1, score becomes score+1 in BCD. The new value is visible immediately after that edge (1-cycle latency from pass sampled high).
  - Digit rule: if carry-in and digit==9, digit becomes 0 and carry-out=1.
  - Otherwise digit becomes digit+carry-in and carry-out=0.
  - Digit 0 carry-in = inc.
- Saturation: when every digit is 9, inc is ignored and score holds at the maximum (999 for 3 digits). There is no wrap.
- High score: on the PLAY->OVER edge, high <= score if score > high (unsigned BCD compare, MSD first). Equal scores leave high unchanged.
- Simultaneous events:
  - crash with a pass rising edge: crash wins, no point is added, and the high-score compare uses the pre-edge score.
  - start with crash while in PLAY: crash wins and state goes to OVER.
  - crash in IDLE or OVER: ignored.
  - start in PLAY: ignored.
- disp is combinational from the registers: select score or high by show_high, then apply blanking.
  - Blanking replaces a digit with 4'hF when it and all more significant digits are 0.
  - Digit 0 is never blanked.
- Reset mid-game: immediate return to IDLE with score=0 and high=0. The high score is volatile.
- Register values never leave 0..9 per digit. 4'hF appears only on disp.

Decomposition:
- Shared package flappy_pkg:
  - game state enum {IDLE, PLAY, OVER}.
  - BCD_BLANK = 4'hF.
  - BCD_MAX_DIGIT = 4'd9.
- One sub-module, bcd_digit_inc: a single-digit incrementer with inputs digit and cin, and outputs next_digit and cout.
  - Instantiated NUM_DIGITS times in a generate chain.
- Top level holds the FSM, the pass edge detector, the saturation check, the high-score compare and the blanking mux.

Test Plan:
- Reset mid-count with score=042: assert reset_n=0 asynchronously -> score=000, high=000, playing=0, disp={F,F,0} before the next clock edge.
- start, then 12 separate pass pulses (each 3 cycles high) -> score=012, disp={F,1,2}.
  - pass held high for 10 cycles counts once.
- Pass pulse when score=099 -> 100. Pass pulse when score=999 -> remains 999.
- Game 1 ends with crash at 007 -> high=007. Game 2: start gives score=000, then 003 and crash -> high stays 007.
  - Then show_high=1 -> disp={F,F,7}.
- crash in the same cycle as a pass rising edge at score=005 -> score=005, state OVER, high=005.
  - A later pass in OVER adds no point.
- pass held high across a start -> no point until pass falls and rises again.
  - start asserted together with crash in PLAY -> state ends OVER.
